// File: rtl/ttl_pkg.sv
// Shared types and constants for the TTL-equivalent logic blocks.
package ttl_pkg;

  // One-shot FSM states.
  typedef enum logic {
    OS_IDLE,
    OS_ACTIVE
  } oneshot_state_t;

  // Default pulse width in drive-clock cycles.
  localparam int ONESHOT_DEFAULT_TICKS = 16;

endpackage : ttl_pkg

// File: rtl/ttl_oneshot_if.sv
// Trigger/clear inputs and pulse outputs of the one-shot.
// The master side drives the triggers. The slave side is the one-shot itself.
interface ttl_oneshot_if;

  logic A_N;
  logic B;
  logic CLR_N;
  logic Q;
  logic Q_N;
  logic END_STB;

  modport master (
    output A_N,
    output B,
    output CLR_N,
    input  Q,
    input  Q_N,
    input  END_STB
  );

  modport slave (
    input  A_N,
    input  B,
    input  CLR_N,
    output Q,
    output Q_N,
    output END_STB
  );

endinterface : ttl_oneshot_if

// File: rtl/edge_det.sv
// Single-bit edge detector.
// It holds the previous sample of the input in a register that resets to RST_VAL.
// The edge output is combinational in the current cycle.
// DETECT_FALL chooses which edge it flags: 1 for a falling edge, 0 for a rising edge.
module edge_det #(
  parameter logic RST_VAL     = 1'b0,
  parameter bit   DETECT_FALL = 1'b0
) (
  input  logic CLK_DRV,
  input  logic RESET,
  input  logic d,
  output logic edge_o
);

  logic d_dly_reg;

  // Previous-cycle sample of the input.
  always_ff @(posedge CLK_DRV or posedge RESET) begin
    if (RESET) begin
      d_dly_reg <= RST_VAL;
    end else begin
      d_dly_reg <= d;
    end
  end

  generate
    if (DETECT_FALL) begin : g_fall
      assign edge_o = d_dly_reg & ~d;
    end else begin : g_rise
      assign edge_o = ~d_dly_reg & d;
    end
  endgenerate

endmodule : edge_det

// File: rtl/ttl_oneshot.sv
// 74123-style monostable, modelled synchronously on CLK_DRV.
// A tick counter stands in for the RC timing network.
// The outputs are Q, Q_N and a one-cycle END_STB when a pulse expires on its own.
// Build option: define ONESHOT_RETRIGGER_EN for 74123 behaviour, where a trigger
// during a pulse reloads the counter. The default build gives 74121 behaviour:
// triggers during a pulse are ignored.
module ttl_oneshot
  import ttl_pkg::*;
#(
  parameter  int WIDTH_TICKS = ONESHOT_DEFAULT_TICKS,
  localparam int CNT_W       = $clog2(WIDTH_TICKS + 1)
) (
  input logic          CLK_DRV,
  input logic          RESET,
  ttl_oneshot_if.slave bus
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(WIDTH_TICKS - 1);

  // Edge detectors, indexed 0: A_N fall, 1: B rise, 2: CLR_N rise.
  localparam logic [2:0] EDGE_RST  = 3'b101;
  localparam logic [2:0] EDGE_FALL = 3'b001;

  logic [2:0]     edge_in;
  logic [2:0]     edge_hit;
  logic           trigger;
  logic           armed_reg;
  logic           q;
  oneshot_state_t state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic           end_stb_reg, end_stb_next;

  assign edge_in = {bus.CLR_N, bus.B, bus.A_N};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_edge
      edge_det #(
        .RST_VAL     (EDGE_RST[gi]),
        .DETECT_FALL (EDGE_FALL[gi])
      ) u_edge (
        .CLK_DRV (CLK_DRV),
        .RESET   (RESET),
        .d       (edge_in[gi]),
        .edge_o  (edge_hit[gi])
      );
    end
  endgenerate

  // Mask triggers in the first cycle after reset.
  // The reset values of the delayed samples would otherwise turn a static
  // A_N=0/B=1 level into a false edge.
  always_ff @(posedge CLK_DRV or posedge RESET) begin
    if (RESET) begin
      armed_reg <= 1'b0;
    end else begin
      armed_reg <= 1'b1;
    end
  end

  assign trigger = armed_reg & bus.CLR_N &
                   ((edge_hit[0] & bus.B) |
                    (edge_hit[1] & ~bus.A_N) |
                    (edge_hit[2] & ~bus.A_N & bus.B));

  // State, counter and end-of-pulse strobe registers.
  always_ff @(posedge CLK_DRV or posedge RESET) begin
    if (RESET) begin
      state_reg   <= OS_IDLE;
      cnt_reg     <= '0;
      end_stb_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      end_stb_reg <= end_stb_next;
    end
  end

  // Next state: clear overrides everything; otherwise start, count down or expire.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    end_stb_next = 1'b0;
    if (!bus.CLR_N) begin
      state_next = OS_IDLE;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        OS_IDLE: begin
          if (trigger) begin
            state_next = OS_ACTIVE;
            cnt_next   = RELOAD;
          end
        end
        OS_ACTIVE: begin
`ifdef ONESHOT_RETRIGGER_EN
          if (trigger) begin
            cnt_next = RELOAD;
          end else
`endif
          if (cnt_reg != '0) begin
            cnt_next = cnt_reg - CNT_W'(1);
          end else begin
            state_next   = OS_IDLE;
            end_stb_next = 1'b1;
          end
        end
        default: begin
          state_next = OS_IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // Clear gates Q combinationally, so Q drops in the same cycle CLR_N falls.
  assign q           = (state_reg == OS_ACTIVE) & bus.CLR_N;
  assign bus.Q       = q;
  assign bus.Q_N     = ~q;
  assign bus.END_STB = end_stb_reg;

endmodule : ttl_oneshot

// File: tb/tb_ttl_oneshot.sv
// Scoreboard bench for ttl_oneshot with WIDTH_TICKS=5.
// Each directed scenario pushes the Q edges and END_STB pulses it expects,
// tagged with scenario-relative cycle numbers. A negedge monitor pops and
// compares an entry every time the DUT shows such an event.
module tb_ttl_oneshot;

  localparam int W = 5;
  localparam int EV_RISE = 0;
  localparam int EV_FALL = 1;
  localparam int EV_END  = 2;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  logic CLK_DRV = 1'b0;
  logic RESET   = 1'b1;

  ttl_oneshot_if bus();

  ttl_oneshot #(.WIDTH_TICKS(W)) dut (
    .CLK_DRV (CLK_DRV),
    .RESET   (RESET),
    .bus     (bus)
  );

  always #5 CLK_DRV = ~CLK_DRV;

  ev_t  exp_q[$];
  int   cyc      = 0;
  int   base     = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  logic q_prev   = 1'b0;

  always @(posedge CLK_DRV) cyc <= cyc + 1;

  function automatic string kname(input int k);
    case (k)
      EV_RISE: return "Q_rise";
      EV_FALL: return "Q_fall";
      default: return "END_STB";
    endcase
  endfunction

  task automatic expect_ev(input int k, input int c);
    ev_t e;
    e.kind = k;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic check_event(input int k);
    ev_t e;
    int  rel;
    rel = cyc - base;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $display("FAIL unexpected_event: got %s at cycle %0d, required none", kname(k), rel);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.cyc != rel) begin
        n_errors++;
        $display("FAIL event_order: got %s at cycle %0d, required %s at cycle %0d",
                 kname(k), rel, kname(e.kind), e.cyc);
      end else begin
        $display("event %s at cycle %0d ok", kname(k), rel);
      end
    end
  endtask

  // Monitor: Q_N complement check every cycle, plus scoreboard pops on events.
  always @(negedge CLK_DRV) begin
    n_checks++;
    if (bus.Q_N !== ~bus.Q) begin
      n_errors++;
      $display("FAIL q_n_complement: got Q=%b Q_N=%b, required Q_N=~Q", bus.Q, bus.Q_N);
    end
    if (bus.Q !== q_prev) check_event(bus.Q ? EV_RISE : EV_FALL);
    if (bus.END_STB === 1'b1) check_event(EV_END);
    q_prev = bus.Q;
  end

  task automatic check_bit(input string name, input logic got, input logic req);
    n_checks++;
    if (got !== req) begin
      n_errors++;
      $display("FAIL %s: got %b required %b", name, got, req);
    end else begin
      $display("check %s = %b ok", name, got);
    end
  endtask

  task automatic wait_cycle(input int k);
    while (cyc - base < k) begin
      @(posedge CLK_DRV);
      #1;
    end
  endtask

  task automatic start_scn(input string name);
    RESET = 1'b1;
    @(posedge CLK_DRV);
    #1;
    @(posedge CLK_DRV);
    #1;
    RESET = 1'b0;
    base  = cyc;
    $display("scenario %s starts", name);
  endtask

  task automatic end_scn(input string name);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL %s_missing_events: got %0d pending, required 0 (next %s at cycle %0d)",
               name, exp_q.size(), kname(exp_q[0].kind), exp_q[0].cyc);
    end else begin
      $display("scenario %s complete ok", name);
    end
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.A_N   = 1'b1;
    bus.B     = 1'b1;
    bus.CLR_N = 1'b1;

    // Reset state
    @(posedge CLK_DRV);
    #1;
    check_bit("reset_Q", bus.Q, 1'b0);
    check_bit("reset_Q_N", bus.Q_N, 1'b1);
    check_bit("reset_END_STB", bus.END_STB, 1'b0);

    // Basic pulse: A_N falls with B high
    bus.A_N = 1'b1; bus.B = 1'b1; bus.CLR_N = 1'b1;
    start_scn("basic");
    expect_ev(EV_RISE, 11);
    expect_ev(EV_FALL, 16);
    expect_ev(EV_END, 16);
    wait_cycle(10); bus.A_N = 1'b0;
    wait_cycle(25);
    end_scn("basic");

    // Static trigger level held through reset release
    bus.A_N = 1'b0; bus.B = 1'b1; bus.CLR_N = 1'b1;
    start_scn("level");
    wait_cycle(20);
    end_scn("level");

    // Clear mid-pulse, then trigger from CLR_N rising
    bus.A_N = 1'b0; bus.B = 1'b0; bus.CLR_N = 1'b1;
    start_scn("clear");
    expect_ev(EV_RISE, 11);
    expect_ev(EV_FALL, 12);
    expect_ev(EV_RISE, 21);
    expect_ev(EV_FALL, 26);
    expect_ev(EV_END, 26);
    wait_cycle(10); bus.B = 1'b1;
    wait_cycle(12); bus.CLR_N = 1'b0;
    wait_cycle(20); bus.CLR_N = 1'b1;
    wait_cycle(30);
    end_scn("clear");

    // Retrigger at cycle 13
    bus.A_N = 1'b1; bus.B = 1'b1; bus.CLR_N = 1'b1;
    start_scn("retrigger");
    expect_ev(EV_RISE, 11);
`ifdef ONESHOT_RETRIGGER_EN
    expect_ev(EV_FALL, 19);
    expect_ev(EV_END, 19);
`else
    expect_ev(EV_FALL, 16);
    expect_ev(EV_END, 16);
`endif
    wait_cycle(10); bus.A_N = 1'b0;
    wait_cycle(12); bus.A_N = 1'b1;
    wait_cycle(13); bus.A_N = 1'b0;
    wait_cycle(25);
    end_scn("retrigger");

    // Second trigger in the cnt==0 cycle (15)
    bus.A_N = 1'b1; bus.B = 1'b1; bus.CLR_N = 1'b1;
    start_scn("boundary_cnt0");
    expect_ev(EV_RISE, 11);
`ifdef ONESHOT_RETRIGGER_EN
    expect_ev(EV_FALL, 21);
    expect_ev(EV_END, 21);
`else
    expect_ev(EV_FALL, 16);
    expect_ev(EV_END, 16);
`endif
    wait_cycle(10); bus.A_N = 1'b0;
    wait_cycle(14); bus.A_N = 1'b1;
    wait_cycle(15); bus.A_N = 1'b0;
    wait_cycle(28);
    end_scn("boundary_cnt0");

    // Trigger in the END_STB cycle (16) starts a fresh pulse
    bus.A_N = 1'b1; bus.B = 1'b1; bus.CLR_N = 1'b1;
    start_scn("boundary_endstb");
    expect_ev(EV_RISE, 11);
    expect_ev(EV_FALL, 16);
    expect_ev(EV_END, 16);
    expect_ev(EV_RISE, 17);
    expect_ev(EV_FALL, 22);
    expect_ev(EV_END, 22);
    wait_cycle(10); bus.A_N = 1'b0;
    wait_cycle(15); bus.A_N = 1'b1;
    wait_cycle(16); bus.A_N = 1'b0;
    wait_cycle(30);
    end_scn("boundary_endstb");

    // Asynchronous reset mid-pulse
    bus.A_N = 1'b1; bus.B = 1'b1; bus.CLR_N = 1'b1;
    start_scn("async_reset");
    expect_ev(EV_RISE, 11);
    expect_ev(EV_FALL, 13);
    wait_cycle(10); bus.A_N = 1'b0;
    wait_cycle(13); RESET = 1'b1;
    #1;
    check_bit("async_reset_Q", bus.Q, 1'b0);
    check_bit("async_reset_END_STB", bus.END_STB, 1'b0);
    wait_cycle(22);
    end_scn("async_reset");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_ttl_oneshot
